// File: rtl/yadmc_defs.sv
// yadmc_defs: shared Wishbone widths and arbiter state encoding for the YADMC bus slice
package yadmc_defs;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  typedef enum logic [1:0] {IDLE, OWN, HOLD} arb_state_t;
endpackage

// File: rtl/yadmc_rr_pick.sv
// yadmc_rr_pick: round-robin requester search starting after the last granted index
module yadmc_rr_pick #(
  parameter int nmasters = 4,
  parameter int iw = $clog2(nmasters)
) (
  input  logic [nmasters-1:0] req,
  input  logic [iw-1:0]       last,
  output logic [nmasters-1:0] pick,
  output logic [iw-1:0]       idx,
  output logic                valid
);
  always_comb begin
    pick = '0;
    idx = '0;
    valid = 1'b0;
    // walk from farthest to nearest so the closest requester after last wins
    for (int i = nmasters; i >= 1; i--) begin
      if (req[(int'(last) + i) % nmasters]) begin
        pick = nmasters'(1) << ((int'(last) + i) % nmasters);
        idx = iw'((int'(last) + i) % nmasters);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/yadmc_wb_arbiter.sv
// yadmc_wb_arbiter: round-robin Wishbone arbiter with per-grant transfer quota
// in front of the YADMC controller slave port.
module yadmc_wb_arbiter
  import yadmc_defs::*;
#(
  parameter int nmasters = 4,
  parameter int quota = 8,
  parameter int quota_width = 8
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [WB_ADR_W*nmasters-1:0] m_adr_i,
  input  logic [WB_DAT_W*nmasters-1:0] m_dat_i,
  input  logic [WB_SEL_W*nmasters-1:0] m_sel_i,
  input  logic [nmasters-1:0]          m_we_i,
  input  logic [nmasters-1:0]          m_cyc_i,
  input  logic [nmasters-1:0]          m_stb_i,
  output logic [WB_DAT_W-1:0]          m_dat_o,
  output logic [nmasters-1:0]          m_ack_o,
  output logic [WB_ADR_W-1:0]          s_adr_o,
  output logic [WB_DAT_W-1:0]          s_dat_o,
  output logic [WB_SEL_W-1:0]          s_sel_o,
  output logic                         s_we_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  input  logic [WB_DAT_W-1:0]          s_dat_i,
  input  logic                         s_ack_i,
  output logic [nmasters-1:0]          gnt_o
);
  localparam int iw = $clog2(nmasters);
  localparam logic [quota_width-1:0] qlast = quota_width'(quota == 0 ? 0 : quota - 1);
  arb_state_t state, state_n;
  logic [nmasters-1:0] gnt, gnt_n, req, pick;
  logic [iw-1:0] last, last_n, pick_idx;
  logic [quota_width-1:0] cnt, cnt_n;
  logic pick_v, hold, own_cyc, own_stb, ack, handover, at_quota;
  assign hold = state == HOLD;
  assign req = m_cyc_i & ~gnt;
  assign own_cyc = |(m_cyc_i & gnt);
  assign own_stb = |(m_stb_i & gnt);
  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_stb & ~hold;
  assign ack = s_ack_i & s_stb_o;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = gnt & {nmasters{s_ack_i & ~hold}};
  assign gnt_o = gnt;
  assign handover = state != OWN || !own_cyc;
  assign at_quota = quota != 0 && cnt == qlast;
  yadmc_rr_pick #(.nmasters(nmasters), .iw(iw)) u_pick (
    .req(req),
    .last(last),
    .pick(pick),
    .idx(pick_idx),
    .valid(pick_v)
  );
  // AND-OR mux is sufficient because gnt is one-hot or zero
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o = 1'b0;
    for (int k = 0; k < nmasters; k++) begin
      s_adr_o |= m_adr_i[WB_ADR_W*k +: WB_ADR_W] & {WB_ADR_W{gnt[k]}};
      s_dat_o |= m_dat_i[WB_DAT_W*k +: WB_DAT_W] & {WB_DAT_W{gnt[k]}};
      s_sel_o |= m_sel_i[WB_SEL_W*k +: WB_SEL_W] & {WB_SEL_W{gnt[k]}};
      s_we_o |= m_we_i[k] & gnt[k];
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      gnt <= '0;
      last <= iw'(nmasters - 1);
      cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      last <= last_n;
      cnt <= cnt_n;
    end
  end
  // grants only move when no strobe is pending: idle, after the hold cycle, or owner released
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    last_n = last;
    cnt_n = cnt;
    if (handover) begin
      cnt_n = '0;
      state_n = pick_v ? OWN : (hold && own_cyc) ? OWN : IDLE;
      gnt_n = pick_v ? pick : (hold && own_cyc) ? gnt : '0;
      last_n = pick_v ? pick_idx : last;
    end else if (ack) begin
      state_n = (at_quota && pick_v) ? HOLD : OWN;
      cnt_n = at_quota ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_yadmc_wb_arbiter.sv
// tb_yadmc_wb_arbiter: vector table, directed corner cases and randomized model check
module tb_yadmc_wb_arbiter;
  localparam int N = 4;
  localparam int Q = 8;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [32*N-1:0] m_adr_i, m_dat_i;
  logic [4*N-1:0] m_sel_i;
  logic [N-1:0] m_we_i, m_cyc_i, m_stb_i, m_ack_o, gnt_o;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [3:0] s_sel_o;
  logic s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  int tests = 0;
  int fails = 0;
  int mo, ml, mc;
  bit mh;
  typedef struct {
    logic [3:0] cyc, stb;
    logic ack;
    logic [3:0] gnt, mack;
    logic stb_o;
  } vec_t;
  vec_t tbl[12];

  always #5 sys_clk = ~sys_clk;

  yadmc_wb_arbiter #(.nmasters(N), .quota(Q), .quota_width(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; s_dat_i = '0; s_ack_i = 1'b0;
  endtask

  task automatic next_cyc;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_rst_n = 1'b0;
    clear_in();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    next_cyc();
  endtask

  function automatic int pick(input int excl);
    for (int i = 1; i <= N; i++)
      if (m_cyc_i[(ml + i) % N] && (ml + i) % N != excl) return (ml + i) % N;
    return -1;
  endfunction

  task automatic model_chk(input int c);
    logic [3:0] g, a, sel;
    logic [31:0] adr, dat;
    logic cy, st, we;
    g = '0; a = '0; sel = '0; adr = '0; dat = '0; cy = 0; st = 0; we = 0;
    if (mo >= 0) begin
      g[mo] = 1'b1;
      a[mo] = s_ack_i & !mh;
      cy = m_cyc_i[mo];
      st = m_stb_i[mo] & !mh;
      we = m_we_i[mo];
      adr = m_adr_i[32*mo +: 32];
      dat = m_dat_i[32*mo +: 32];
      sel = m_sel_i[4*mo +: 4];
    end
    chk($sformatf("rand[%0d]", c),
        {gnt_o, m_ack_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, m_dat_o},
        {g, a, cy, st, we, sel, adr, dat, s_dat_i});
  endtask

  task automatic model_step;
    int p;
    if (mo < 0) begin
      p = pick(-1);
      if (p >= 0) begin mo = p; ml = p; mc = 0; end
    end else if (mh || !m_cyc_i[mo]) begin
      p = pick(mo);
      mh = 0;
      mc = 0;
      if (p >= 0) begin mo = p; ml = p; end
      else if (!m_cyc_i[mo]) mo = -1;
    end else if (m_stb_i[mo] && s_ack_i) begin
      if (mc == Q - 1 && pick(mo) >= 0) begin mh = 1; mc = 0; end
      else mc = (mc + 1) % Q;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, bad;
    bit seen;
    clear_in();
    #2;
    chk("reset_outputs", {gnt_o, m_ack_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, '0);

    // reset asserted mid-transfer clears everything combinationally
    do_reset();
    m_cyc_i = 4'b1111; m_stb_i = 4'b1111; m_adr_i = {4{32'h1111_2222}};
    @(negedge sys_clk);
    next_cyc();
    s_ack_i = 1'b1;
    @(negedge sys_clk);
    chk("pre_rst_own", {gnt_o, s_stb_o, m_ack_o}, {4'b0001, 1'b1, 4'b0001});
    #2 sys_rst_n = 1'b0;
    #1 chk("async_rst", {gnt_o, s_cyc_o, s_stb_o, m_ack_o, s_adr_o}, '0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    s_ack_i = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("post_rst_first_m0", gnt_o, 4'b0001);

    // single master read
    do_reset();
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010; m_adr_i[63:32] = 32'h1234_5670; m_sel_i[7:4] = 4'hf;
    @(negedge sys_clk);
    chk("read_c0", {gnt_o, s_cyc_o, s_stb_o}, '0);
    next_cyc();
    @(negedge sys_clk);
    chk("read_c1", {gnt_o, s_cyc_o, s_stb_o, s_adr_o, s_sel_o, m_ack_o},
        {4'b0010, 1'b1, 1'b1, 32'h1234_5670, 4'hf, 4'b0000});
    next_cyc();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    chk("read_c2", {m_ack_o, m_dat_o}, {4'b0010, 32'hDEAD_BEEF});

    // round-robin table including a stray ack while idle
    tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1};
    tbl[2]  = '{4'b1110, 4'b1110, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[3]  = '{4'b1110, 4'b1110, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tbl[4]  = '{4'b1100, 4'b1100, 1'b0, 4'b0010, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1100, 4'b1100, 1'b1, 4'b0100, 4'b0100, 1'b1};
    tbl[6]  = '{4'b1000, 4'b1000, 1'b0, 4'b0100, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0001, 1'b0, 4'b1000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      m_cyc_i = tbl[i].cyc; m_stb_i = tbl[i].stb; s_ack_i = tbl[i].ack;
      @(negedge sys_clk);
      chk($sformatf("rr[%0d]", i), {gnt_o, m_ack_o, s_stb_o}, {tbl[i].gnt, tbl[i].mack, tbl[i].stb_o});
      next_cyc();
    end

    // quota with contention: 8 acks, one hold cycle, then m2, then back to m0
    do_reset();
    m_cyc_i = 4'b0101; m_stb_i = 4'b0101;
    next_cyc();
    s_ack_i = 1'b1;
    acks = 0; seen = 0; bad = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sys_clk);
      if (gnt_o == 4'b0001 && !s_stb_o) begin
        seen = 1;
        if (m_ack_o != 4'b0000) bad++;
      end else begin
        acks += int'(m_ack_o[0]);
        next_cyc();
      end
    end
    chk("quota_hold_seen", 128'(seen), 128'(1));
    chk("quota_acks", 128'(acks), 128'(Q));
    chk("quota_hold_noack", 128'(bad), 128'(0));
    next_cyc();
    @(negedge sys_clk);
    chk("quota_to_m2", {gnt_o, m_ack_o, s_stb_o}, {4'b0100, 4'b0100, 1'b1});
    next_cyc();
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001; s_ack_i = 1'b0;
    next_cyc();
    @(negedge sys_clk);
    chk("quota_back_m0", gnt_o, 4'b0001);

    // quota without contention: grant kept through 20 acks
    do_reset();
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001; s_ack_i = 1'b1;
    next_cyc();
    acks = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (gnt_o != 4'b0001 || m_ack_o != 4'b0001 || !s_stb_o) bad++;
      acks += int'(m_ack_o[0]);
      next_cyc();
    end
    chk("solo_no_hold", 128'(bad), 128'(0));
    chk("solo_acks", 128'(acks), 128'(20));

    // randomized traffic against the reference model
    do_reset();
    mo = -1; ml = N - 1; mc = 0; mh = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(15) == 0) m_cyc_i[k] = ~m_cyc_i[k];
      m_stb_i = m_cyc_i & ~(4'($urandom) & 4'($urandom));
      m_we_i = 4'($urandom);
      m_sel_i = 16'($urandom);
      m_adr_i = {$urandom, $urandom, $urandom, $urandom};
      m_dat_i = {$urandom, $urandom, $urandom, $urandom};
      s_dat_i = $urandom;
      s_ack_i = $urandom_range(3) != 0;
      @(negedge sys_clk);
      model_chk(c);
      model_step();
      next_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/yadmc_wb_arbiter.md
Name: yadmc_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single Wishbone slave port of the YADMC cache/SDRAM controller between up to nmasters requesters (CPU instruction bus, CPU data bus, video DMA, …).
- Grants are held for a master's whole bus cycle (cyc high). A per-grant transaction quota forces re-arbitration between transfers, so one streaming master cannot starve others.
- Sits directly in front of the controller's wb_* inputs, in the sys_clk domain.

Parameters:
- nmasters, 4, number of requesting masters (2..8).
- quota, 8, transfers (acks) a master may take per grant while another master is requesting; 0 means unlimited.
- quota_width, 8, width of the transfer counter; quota < 2^quota_width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- m_adr_i  in  32*nmasters  master addresses; master k uses bits [32k+31:32k].
- m_dat_i  in  32*nmasters  master write data, same packing.
- m_sel_i  in  4*nmasters  master byte selects.
- m_we_i  in  nmasters  master write enables.
- m_cyc_i  in  nmasters  master cycle signals.
- m_stb_i  in  nmasters  master strobes.
- m_dat_o  out  32  read data, broadcast to all masters (= s_dat_i).
- m_ack_o  out  nmasters  per-master ack.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  nmasters  one-hot current grant (status/debug).

Behaviour:
- Registered state:
  - gnt: one-hot, or all zero = no owner.
  - last: index of the last granted master.
  - cnt: quota_width bits.
- Reset (async, sys_rst_n low):
  - gnt=0, last=nmasters-1, cnt=0.
  - Consequently s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=s_dat_o=0, s_sel_o=0, m_ack_o=0, gnt_o=0.
  - All these take effect immediately on assertion, not at the next edge.
- Slave-side outputs are combinational muxes of the granted master's signals.
  - s_cyc_o = m_cyc_i[g] & owned; s_stb_o = m_stb_i[g] & owned & !hold.
  - When gnt=0, all s_* outputs are 0.
- m_ack_o[k] = s_ack_i & gnt[k] & !hold. An ack is never routed to an ungranted master. s_ack_i with gnt=0 is ignored.
- States:
  - IDLE (gnt=0): requesters req = m_cyc_i. If req≠0, the round-robin pick (search last+1, last+2, … wrapping) is loaded into gnt and last at the next edge; cnt=0. Grant latency: 1 cycle from cyc assertion to s_cyc_o.
  - OWN (gnt≠0):
    - Each cycle with s_ack_i & s_stb_o: cnt<=cnt+1.
    - Release when the owner drops m_cyc_i. If other requesters exist in that same cycle, the new grant loads at the next edge (no extra idle cycle); otherwise → IDLE.
    - Quota release: quota≠0, an ack occurs with cnt==quota-1, and any other master has m_cyc_i high. After that ack edge, set hold=1 (one-cycle state): s_stb_o masked, owner sees no ack. Next edge: grant passes to the round-robin pick among the other requesters.
    - The old owner stays waiting (cyc/stb high) and re-competes normally.
- Quota reached with no other requester: cnt wraps to 0, grant kept.
- Transfers are never aborted. A grant changes only when no strobe is outstanding: after an ack, or when the owner's cyc is low.
- Owner drops cyc while s_stb_o is high: this is a master protocol violation. The arbiter still releases. The slave's pending cycle is the master's responsibility.
- Wrap-around: pointer search is modulo nmasters. With nmasters masters all requesting, grant order is last+1 … last+nmasters.

Decomposition:
- Shared package/header yadmc_defs: WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
- Sub-module yadmc_rr_pick (combinational): inputs req[nmasters] and last index; outputs one-hot pick and its index. Instantiated once for IDLE/release decisions.

Test Plan:
- Reset mid-transfer: m0 owns with stb high, then sys_rst_n=0 → s_cyc_o/s_stb_o/m_ack_o fall in the same cycle; gnt_o=0; after release, first grant goes to m0 (last=3).
- Single master read: m1 cyc/stb at cycle 0, slave acks at cycle 2 with s_dat_i=0xDEADBEEF → gnt_o=0010 at cycle 1, m_ack_o=0010 at cycle 2 with m_dat_o=0xDEADBEEF.
- Round-robin: all four masters raise cyc at once after reset, each releases after 1 ack → grant order m0,m1,m2,m3,m0.
- Quota: quota=8, m0 streams and m2 requests → exactly 8 acks to m0, one hold cycle with s_stb_o=0, then gnt_o=0100; m0 regains the grant after m2 drops cyc.
- Quota without contention: m0 alone, 20 acks → gnt_o stays 0001 throughout, no hold cycles.
- Stray ack: s_ack_i pulsed while gnt=0 → m_ack_o stays 0000.
